// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, NUM_RD
// combinational read ports and a self-clearing sweep.
// The sweep runs after reset or on a clr request, zeroing one register per cycle.
// Optional feature macro: REGFILE_MP_BYPASS_EN forwards same-cycle write data to reads.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    output logic                     busy,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    // Register 0 is read-only zero when ZERO_REG is set.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Value seen by one read port: zero while clearing or for hardwired register 0.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (state == RUN && writable(a)) begin
            v = mem[a];
`ifdef REGFILE_MP_BYPASS_EN
            if (we0 && (wa0 == a)) v = wd0;
            if (we1 && (wa1 == a)) v = wd1;
`endif
        end
        return v;
    endfunction

    // Sweep/run state machine and storage updates; port 1 is applied last so it wins collisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    mem[cnt[ADDR_W-1:0]] <= '0;
                    cnt <= cnt + CNT_ONE;
                    if (cnt == LAST_ADDR) state <= RUN;
                end
                RUN: begin
                    if (we0 && writable(wa0)) mem[wa0] <= wd0;
                    if (we1 && writable(wa1)) mem[wa1] <= wd1;
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == CLEAR);

    // Independent combinational read ports.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k*DATA_W +: DATA_W] = read_port(rd_addr[k*ADDR_W +: ADDR_W]);
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against an
// array-based reference model (default parameters).
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic        clr;
    logic        busy;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] modelMem [32];
    int          clearLeft = 0;

    regfile_mp dut (
        .clk(clk), .reset(reset), .clr(clr), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model's view of the block at a rising edge.
    task automatic modelEdge();
        if (reset) begin
            clearLeft = 32;
            foreach (modelMem[i]) modelMem[i] = '0;
        end else if (clearLeft > 0) begin
            clearLeft--;
        end else begin
            if (we0 && wa0 != 0) modelMem[wa0] = wd0;
            if (we1 && wa1 != 0) modelMem[wa1] = wd1;
            if (clr) begin
                clearLeft = 32;
                foreach (modelMem[i]) modelMem[i] = '0;
            end
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        logic [31:0] v;
        if (clearLeft > 0 || a == 0) return 32'h0;
        v = modelMem[a];
`ifdef REGFILE_MP_BYPASS_EN
        if (we0 && wa0 == a) v = wd0;
        if (we1 && wa1 == a) v = wd1;
`endif
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 1'b0; clr = 1'b0;
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        rd_addr = '0;
    endtask

    // Random writes and reads; read port 0 often targets a write address to exercise collisions.
    task automatic applyStimulus();
        reset = 1'b0; clr = 1'b0;
        we0 = 1'($urandom); wa0 = 5'($urandom); wd0 = $urandom;
        we1 = 1'($urandom); wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom); wd1 = $urandom;
        rd_addr = 10'($urandom);
        if ($urandom_range(0, 1) == 0) rd_addr[4:0] = wa0;
        if ($urandom_range(0, 3) == 0) rd_addr[9:5] = wa1;
    endtask

    task automatic checkOutput(input string tag);
        logic        expBusy;
        logic [31:0] exp;
        expBusy = (clearLeft > 0);
        vectors++;
        assert (busy === expBusy) else begin
            errors++;
            $error("[TB] FAIL %s busy: got %b want %b", tag, busy, expBusy);
        end
        for (int k = 0; k < 2; k++) begin
            exp = modelRead(rd_addr[k*5 +: 5]);
            vectors++;
            assert (rd_data[k*32 +: 32] === exp) else begin
                errors++;
                $error("[TB] FAIL %s rd%0d addr %0d: got %h want %h", tag, k, rd_addr[k*5 +: 5], rd_data[k*32 +: 32], exp);
            end
        end
    endtask

    task automatic expectRead(input int port, input logic [4:0] a, input logic [31:0] want, input string tag);
        rd_addr[port*5 +: 5] = a;
        #1;
        vectors++;
        assert (rd_data[port*32 +: 32] === want) else begin
            errors++;
            $error("[TB] FAIL %s rd%0d addr %0d: got %h want %h", tag, port, a, rd_data[port*32 +: 32], want);
        end
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            applyStimulus();
            #1 checkOutput("sweep");
            n++;
            cycle();
        end
    endtask

    task automatic expectCount(input int got, input int want, input string tag);
        vectors++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s busy cycles: got %0d want %0d", tag, got, want);
        end
    endtask

    // Directed sequence followed by random traffic and sweep scenarios.
    initial begin
        int n;
        logic [31:0] bypExp;
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        countBusy(n);
        expectCount(n, 32, "reset_sweep");
        idle(); #1 checkOutput("post_reset");

        idle(); we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        #1 checkOutput("wr5");
        cycle();
        idle(); expectRead(1, 5'd5, 32'hDEADBEEF, "rd5");
        idle(); we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h12345678;
        cycle();
        idle(); expectRead(0, 5'd0, 32'h0, "rd0");

        idle(); we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11111111;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22222222;
        cycle();
        idle(); expectRead(0, 5'd7, 32'h22222222, "collide7");

`ifdef REGFILE_MP_BYPASS_EN
        bypExp = 32'hA5A5A5A5;
`else
        bypExp = 32'h00000000;
`endif
        idle(); we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA5A5A5A5;
        expectRead(0, 5'd3, bypExp, "same_cycle3");
        cycle();
        idle(); expectRead(0, 5'd3, 32'hA5A5A5A5, "next_cycle3");

        for (int i = 0; i < 300; i++) begin
            applyStimulus();
            #1 checkOutput("random");
            cycle();
        end

        for (int a = 1; a < 32; a++) begin
            idle(); we0 = 1'b1; wa0 = 5'(a); wd0 = $urandom | 32'h1;
            cycle();
        end
        idle(); rd_addr = {5'd9, 5'd31}; #1 checkOutput("filled");
        clr = 1'b1; we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h99999999;
        #1 checkOutput("clr_edge");
        cycle();
        countBusy(n);
        expectCount(n, 32, "clr_sweep");
        for (int a = 0; a < 32; a++) begin
            idle(); expectRead(a % 2, 5'(a), 32'h0, "after_clr");
        end

        for (int a = 1; a < 32; a += 3) begin
            idle(); we1 = 1'b1; wa1 = 5'(a); wd1 = $urandom | 32'h1;
            cycle();
        end
        idle(); clr = 1'b1; cycle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            #1 checkOutput("pre_reset_sweep");
            cycle();
        end
        idle(); reset = 1'b1; cycle();
        countBusy(n);
        expectCount(n, 32, "mid_sweep_reset");

        idle(); clr = 1'b1; cycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(); cycle();
        end
        applyStimulus(); clr = 1'b1; cycle();
        countBusy(n);
        expectCount(n, 26, "clr_ignored");

        idle(); we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hCAFEF00D; clr = 1'b1; reset = 1'b1;
        cycle();
        countBusy(n);
        expectCount(n, 32, "reset_priority");
        idle(); expectRead(0, 5'd4, 32'h0, "reset_drops_write");

        for (int i = 0; i < 100; i++) begin
            applyStimulus();
            #1 checkOutput("random2");
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, 32: width of each register in bits.
REQ-002 Parameter ADDR_W, 5: register address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, 2: number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, 1: when 1, register 0 is hardwired to zero; when 0, register 0 is an ordinary register.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous active-high reset; starts the clear sweep.
REQ-008 clr  input  1  single-cycle request to re-run the clear sweep without reset.
REQ-009 busy  output  1  high while the clear sweep runs.
REQ-010 rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-011 rd_data  output  NUM_RD*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-012 we0  input  1  write enable, write port 0.
REQ-013 wa0  input  ADDR_W  write address, port 0.
REQ-014 wd0  input  DATA_W  write data, port 0.
REQ-015 we1, wa1, wd1  input  1/ADDR_W/DATA_W  write port 1, same meaning as port 0.

Function
REQ-016 Reads SHALL be combinational (zero latency) from the storage array, independently per port.
REQ-017 With ZERO_REG=1, any read of address 0 SHALL return 0, and writes to address 0 SHALL be discarded.
REQ-018 A write SHALL update the addressed register at the rising clk edge when its enable is high and busy is low.
REQ-019 When both ports write the same address in the same cycle, port 1's data SHALL be stored.
REQ-020 The FSM SHALL have two states: CLEAR (a counter sweeps addresses 0..DEPTH-1, writing 0 to one register per cycle) and RUN (normal operation).
REQ-021 CLEAR SHALL last exactly DEPTH cycles; busy SHALL be high throughout CLEAR and SHALL fall on the cycle after the last address (DEPTH-1) has been cleared.
REQ-022 In CLEAR, we0/we1 SHALL be ignored and every rd_data port SHALL read 0.
REQ-023 When clr is asserted in RUN, the FSM SHALL enter CLEAR with the counter at 0 on the next edge; any write in that same cycle SHALL still be performed before the sweep starts.
REQ-024 A clr asserted during CLEAR SHALL be ignored; the sweep SHALL not restart.
REQ-025 The sweep counter SHALL be ADDR_W+1 bits wide so that DEPTH is detected without wrap-around.

Reset
REQ-026 When reset is high at a clk edge, the FSM SHALL enter CLEAR with the counter at 0, regardless of state or mid-sweep position.
REQ-027 After reset, busy SHALL be 1 and every rd_data port SHALL be 0 until the sweep completes.
REQ-028 Reset SHALL take priority over clr and over both write ports.

Configuration
REQ-029 Macro REGFILE_MP_BYPASS_EN: when defined, a read in RUN of an address being written in the same cycle SHALL return the write data (port 1 data if both ports hit); bypass SHALL never apply to address 0 when ZERO_REG=1.
REQ-030 When REGFILE_MP_BYPASS_EN is undefined, such a read SHALL return the value stored before the edge; the new value SHALL be visible from the next cycle.

Verification
REQ-031 Reset for 1 cycle -> busy=1 for exactly 32 cycles (defaults); all rd_data=0 throughout; busy=0 on cycle 33.
REQ-032 RUN: we0=1, wa0=5, wd0=0xDEADBEEF; next cycle read port 1 addr 5 -> 0xDEADBEEF; write to addr 0 -> addr 0 still reads 0.
REQ-033 we0 and we1 both to addr 7 (0x11111111 / 0x22222222) -> addr 7 reads 0x22222222.
REQ-034 Same-cycle write 0xA5A5A5A5 to addr 3 and read addr 3 -> 0xA5A5A5A5 with REGFILE_MP_BYPASS_EN, old value 0x00000000 without it.
REQ-035 Assert clr in RUN after filling registers 1..31 -> busy=1 for 32 cycles; writes during the sweep are dropped; all registers read 0 afterwards.
REQ-036 Assert reset at sweep cycle 10 -> sweep restarts at address 0; busy stays high for 32 cycles after reset.
